// File: rtl/pwm_audio_out.sv
// Sample-to-PWM audio output stage: one-entry sample buffer behind a valid/ready
// handshake feeding a fixed-period PWM generator with sticky underrun detection.
module pwm_audio_out #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             underrun_clr,
  output logic             pwm_out,
  output logic             period_start,
  output logic             underrun
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]    PS_MAX  = PW'(CLK_DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] buf_data;
  logic             buf_full;

  logic tick, boundary, load, ur_set, run_eff, accept;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The RUN-entry boundary is taken on the IDLE->RUN edge so the first RUN
  // cycle (cnt=0) already compares against the freshly loaded duty.
  always_comb begin
    run_eff      = (state == RUN) && enable;
    tick         = (state == RUN) && (presc == PS_MAX);
    boundary     = enable && ((state == IDLE) || (tick && (cnt == CNT_MAX)));
    load         = boundary && buf_full;
    ur_set       = boundary && !buf_full;
    sample_ready = !buf_full || load;
    accept       = sample_valid && sample_ready;
  end

  // Prescaler and PWM counter; both return to zero whenever not running.
  always_ff @(posedge clk) begin
    if (reset || !run_eff) begin
      presc <= '0;
      cnt   <= '0;
    end else if (tick) begin
      presc <= '0;
      cnt   <= cnt + WIDTH'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                        duty <= '0;
    else if (state == RUN && !enable) duty <= '0;
    else if (load)                    duty <= buf_data;
  end

  // Accept-during-load keeps the buffer full so a stream has no gaps.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_data <= sample_in;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= run_eff && (cnt < duty);
      period_start <= run_eff && (cnt == '0) && (presc == '0);
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk) begin
    if (reset)             underrun <= 1'b0;
    else if (ur_set)       underrun <= 1'b1;
    else if (underrun_clr) underrun <= 1'b0;
  end

endmodule
